// File: rtl/vio_route_sink_pkg.sv
// Shared types for the per-region route sink: route word layout, beat payload, FSM states.
package vio_route_sink_pkg;

  localparam int unsigned AXI_DATA_BITS = 64;
  localparam int unsigned AXI_KEEP_BITS = AXI_DATA_BITS / 8;
  localparam int unsigned PID_BITS      = 6;
  localparam int unsigned ROUTE_BITS    = 14;
  localparam int unsigned HOP_BITS      = 4;
  localparam int unsigned CNT_BITS      = 32;

  localparam logic [HOP_BITS-1:0] HOP_NONE = 4'hF;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [HOP_BITS-1:0] hop0;
    logic [HOP_BITS-1:0] hop1;
    logic [HOP_BITS-1:0] hop2;
    logic [1:0]          flags;
  } route_t;

  typedef struct packed {
    logic [AXI_DATA_BITS-1:0] tdata;
    logic [AXI_KEEP_BITS-1:0] tkeep;
    logic                     tlast;
    logic [PID_BITS-1:0]      tid;
  } axis_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } route_sink_state_t;

  // Shift the hop list down by one and mark the vacated slot empty.
  function automatic route_t route_pop(input route_t r);
    route_t p;
    p.hop0  = r.hop1;
    p.hop1  = r.hop2;
    p.hop2  = HOP_NONE;
    p.flags = r.flags;
    return p;
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_BITS'(1);
  endfunction

endpackage

// File: rtl/vio_route_sink_skid.sv
// Generic 2-entry skid buffer; head entry drives the registered output.
module axis_skid_2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         ready_q, valid_q;
  logic         push_c, pop_c;

  assign push_c = s_valid_i & ready_q;
  assign pop_c  = valid_q & m_ready_i;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case (cnt_q)
      2'd0: begin
        if (push_c) begin
          head_d = s_data_i;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        case ({push_c, pop_c})
          2'b11: head_d = s_data_i;
          2'b10: begin
            tail_d = s_data_i;
            cnt_d  = 2'd2;
          end
          2'b01: cnt_d = 2'd0;
          default: ;
        endcase
      end
      default: begin
        // Full: a pop promotes the tail; a concurrent push refills it.
        if (pop_c) begin
          head_d = tail_q;
          if (push_c) begin
            tail_d = s_data_i;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= (cnt_d != 2'd2);
      valid_q <= (cnt_d != 2'd0);
    end
  end

  assign s_ready_o = ready_q;
  assign m_valid_o = valid_q;
  assign m_data_o  = head_q;

endmodule

// File: rtl/vio_route_sink.sv
// Region egress endpoint: admits packets addressed to this region, drops the rest, pops the route.
module vio_route_sink
  import vio_route_sink_pkg::*;
#(
  parameter int unsigned N_ID      = 16,
  parameter int unsigned N_REGIONS = N_ID,
  parameter int unsigned REGION_ID = 0
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [AXI_DATA_BITS-1:0] s_axis_tdata,
  input  logic [AXI_KEEP_BITS-1:0] s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic [PID_BITS-1:0]      s_axis_tid,
  input  logic [ROUTE_BITS-1:0]    s_route,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [AXI_DATA_BITS-1:0] m_axis_tdata,
  output logic [AXI_KEEP_BITS-1:0] m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [PID_BITS-1:0]      m_axis_tid,
  output logic [ROUTE_BITS-1:0]    route_next,
  output logic                     route_next_valid,
  output logic [CNT_BITS-1:0]      pkt_cnt,
  output logic [CNT_BITS-1:0]      drop_cnt
);

  route_sink_state_t   state_q, state_d;
  route_t              route_next_q, route_next_d;
  logic                route_valid_q, route_valid_d;
  logic [CNT_BITS-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;

  route_t     route_in;
  axis_beat_t beat_in, beat_out;
  logic       skid_ready, skid_push_c, s_hs, dest_hit;

  assign route_in = route_t'(s_route);
  assign dest_hit = (32'(route_in.hop0) == REGION_ID) &&
                    (32'(route_in.hop0) < N_ID) &&
                    (32'(route_in.hop0) < N_REGIONS);

  // DROP swallows beats without touching the skid.
  assign s_axis_tready = (state_q == ST_DROP) | skid_ready;
  assign s_hs          = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_d       = state_q;
    route_next_d  = route_next_q;
    route_valid_d = route_valid_q;
    pkt_cnt_d     = pkt_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    skid_push_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_hs) begin
          if (dest_hit) begin
            skid_push_c   = 1'b1;
            route_next_d  = route_pop(route_in);
            route_valid_d = 1'b1;
            pkt_cnt_d     = sat_inc(pkt_cnt_q);
            if (!s_axis_tlast) state_d = ST_PASS;
          end else begin
            drop_cnt_d = sat_inc(drop_cnt_q);
            if (!s_axis_tlast) state_d = ST_DROP;
          end
        end
      end
      ST_PASS: begin
        if (s_hs) begin
          skid_push_c = 1'b1;
          if (s_axis_tlast) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (s_hs && s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      route_next_q  <= '0;
      route_valid_q <= 1'b0;
      pkt_cnt_q     <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      route_next_q  <= route_next_d;
      route_valid_q <= route_valid_d;
      pkt_cnt_q     <= pkt_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign beat_in = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep,
                     tlast: s_axis_tlast, tid: s_axis_tid};

  axis_skid_2 #(
    .W($bits(axis_beat_t))
  ) u_skid (
    .clk_i    (aclk),
    .rst_i    (areset),
    .s_valid_i(skid_push_c),
    .s_ready_o(skid_ready),
    .s_data_i (beat_in),
    .m_valid_o(m_axis_tvalid),
    .m_ready_i(m_axis_tready),
    .m_data_o (beat_out)
  );

  assign m_axis_tdata     = beat_out.tdata;
  assign m_axis_tkeep     = beat_out.tkeep;
  assign m_axis_tlast     = beat_out.tlast;
  assign m_axis_tid       = beat_out.tid;
  assign route_next       = route_next_q;
  assign route_next_valid = route_valid_q;
  assign pkt_cnt          = pkt_cnt_q;
  assign drop_cnt         = drop_cnt_q;

endmodule
